int_ack_seq: RTL and testbench

Interrupt-acknowledge sequencer between the intel8259 PIC and the CPU core. When the PIC raises its interrupt request, the CPU has interrupts enabled, and the CPU is at an instruction boundary, this block runs the two-pulse 8088-style INTA bus cycle into the PIC. It captures the vector byte the PIC returns and hands it to the CPU over a valid/ready handshake. It is the direct downstream consumer of the PIC's `inta` and `iid` outputs and the only driver of the PIC's `inta_n` input.

---
 rtl/int_ack_pkg.sv | 21 ++
 rtl/ack_phase_counter.sv | 27 ++
 rtl/int_ack_seq.sv | 149 ++++++++++++++
 tb/tb_int_ack_seq.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/int_ack_pkg.sv
// Shared definitions for the interrupt-acknowledge sequencer: state encoding,
// vector range constants and the vector qualification helper.
package int_ack_pkg;

  typedef enum logic [4:0] {
    ST_IDLE = 5'b00001,
    ST_ACK1 = 5'b00010,
    ST_GAP  = 5'b00100,
    ST_ACK2 = 5'b01000,
    ST_HOLD = 5'b10000
  } ack_state_e;

  localparam logic [4:0] VEC_BASE     = 5'b00001;
  localparam logic [7:0] VEC_SPURIOUS = 8'h0F;

  // A PIC vector is genuine only when it falls in the 8-entry block at VEC_BASE.
  function automatic logic vec_is_valid(input logic [7:0] v);
    return (v[7:3] == VEC_BASE);
  endfunction

endpackage

// File: rtl/ack_phase_counter.sv
// 4-bit loadable down-counter that times the ACK1, GAP and ACK2 phases.
module ack_phase_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       zero
);

  logic [3:0] cnt_r;

  // Load on phase entry, otherwise count down and park at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 4'd0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != 4'd0) begin
      cnt_r <= cnt_r - 4'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == 4'd0);

endmodule

// File: rtl/int_ack_seq.sv
// Interrupt-acknowledge sequencer: runs the two-pulse INTA cycle into the PIC,
// captures the returned vector and offers it to the CPU over valid/ready.
module int_ack_seq
  import int_ack_pkg::*;
#(
  parameter int unsigned PULSE_LEN = 2,
  parameter int unsigned GAP_LEN   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       intr,
  input  logic       if_en,
  input  logic       instr_boundary,
  input  logic [7:0] vec_in,
  input  logic       vec_ready,
  output logic       inta_n,
  output logic       lock_n,
  output logic [7:0] vec,
  output logic       vec_valid,
  output logic       spurious,
  output logic       busy
);

  localparam logic [3:0] PULSE_M1 = 4'(PULSE_LEN - 1);
  localparam logic [3:0] GAP_M1   = 4'(GAP_LEN - 1);

  ack_state_e state_r;
  ack_state_e state_nx_s;
  logic       cnt_load_s;
  logic [3:0] cnt_load_val_s;
  logic       cnt_zero_s;
  logic       capture_s;

  logic       inta_n_r;
  logic       lock_n_r;
  logic [7:0] vec_r;
  logic       vec_valid_r;
  logic       spurious_r;
  logic       busy_r;

  ack_phase_counter u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load_s),
    .load_val (cnt_load_val_s),
    .zero     (cnt_zero_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic; once ACK1 is entered the sequence runs to HOLD regardless of inputs.
  always_comb begin
    state_nx_s     = state_r;
    cnt_load_s     = 1'b0;
    cnt_load_val_s = 4'd0;
    capture_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (intr && if_en && instr_boundary) begin
          state_nx_s     = ST_ACK1;
          cnt_load_s     = 1'b1;
          cnt_load_val_s = PULSE_M1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_ACK1: begin
        if (cnt_zero_s) begin
          state_nx_s     = ST_GAP;
          cnt_load_s     = 1'b1;
          cnt_load_val_s = GAP_M1;
        end else begin
          state_nx_s = ST_ACK1;
        end
      end
      ST_GAP: begin
        if (cnt_zero_s) begin
          state_nx_s     = ST_ACK2;
          cnt_load_s     = 1'b1;
          cnt_load_val_s = PULSE_M1;
        end else begin
          state_nx_s = ST_GAP;
        end
      end
      ST_ACK2: begin
        if (cnt_zero_s) begin
          state_nx_s = ST_HOLD;
          capture_s  = 1'b1;
        end else begin
          state_nx_s = ST_ACK2;
        end
      end
      ST_HOLD: begin
        if (vec_ready) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_HOLD;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Strobes are decoded from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inta_n_r    <= 1'b1;
      lock_n_r    <= 1'b1;
      vec_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      inta_n_r    <= !((state_nx_s == ST_ACK1) || (state_nx_s == ST_ACK2));
      lock_n_r    <= (state_nx_s == ST_IDLE) || (state_nx_s == ST_HOLD);
      vec_valid_r <= (state_nx_s == ST_HOLD);
      busy_r      <= (state_nx_s != ST_IDLE);
    end
  end

  // Vector capture at the end of ACK2; out-of-range vectors are replaced by IR7.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_r      <= 8'h00;
      spurious_r <= 1'b0;
    end else if (capture_s) begin
      vec_r      <= vec_is_valid(vec_in) ? vec_in : VEC_SPURIOUS;
      spurious_r <= !vec_is_valid(vec_in);
    end else begin
      vec_r      <= vec_r;
      spurious_r <= spurious_r;
    end
  end

  assign inta_n    = inta_n_r;
  assign lock_n    = lock_n_r;
  assign vec       = vec_r;
  assign vec_valid = vec_valid_r;
  assign spurious  = spurious_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_int_ack_seq.sv
// Directed bench for int_ack_seq: a per-cycle vector table for the default
// build plus hand-written stall, reset and short-pulse sequences.
module tb_int_ack_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       intr, if_en, instr_boundary, vec_ready;
  logic [7:0] vec_in;
  logic       inta_n, lock_n, vec_valid, spurious, busy;
  logic [7:0] vec;

  logic       intr_b, if_en_b, instr_boundary_b, vec_ready_b;
  logic [7:0] vec_in_b;
  logic       inta_n_b, lock_n_b, vec_valid_b, spurious_b, busy_b;
  logic [7:0] vec_b;

  int total = 0;
  int bad   = 0;

  int_ack_seq dut (
    .clk(clk), .rst_n(rst_n), .intr(intr), .if_en(if_en),
    .instr_boundary(instr_boundary), .vec_in(vec_in), .vec_ready(vec_ready),
    .inta_n(inta_n), .lock_n(lock_n), .vec(vec), .vec_valid(vec_valid),
    .spurious(spurious), .busy(busy)
  );

  int_ack_seq #(.PULSE_LEN(1), .GAP_LEN(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .intr(intr_b), .if_en(if_en_b),
    .instr_boundary(instr_boundary_b), .vec_in(vec_in_b), .vec_ready(vec_ready_b),
    .inta_n(inta_n_b), .lock_n(lock_n_b), .vec(vec_b), .vec_valid(vec_valid_b),
    .spurious(spurious_b), .busy(busy_b)
  );

  // exp packs {inta_n, lock_n, vec_valid, busy, spurious, vec[7:0]}
  typedef struct {
    logic        intr;
    logic        if_en;
    logic        bnd;
    logic        rdy;
    logic [7:0]  vin;
    logic [12:0] exp;
  } row_t;

  row_t tbl[$];

  function automatic void add(input logic i, input logic e, input logic b, input logic r,
                              input logic [7:0] vi, input logic ia, input logic lk,
                              input logic vv, input logic bs, input logic sp,
                              input logic [7:0] ev);
    row_t rw;
    rw.intr  = i;
    rw.if_en = e;
    rw.bnd   = b;
    rw.rdy   = r;
    rw.vin   = vi;
    rw.exp   = {ia, lk, vv, bs, sp, ev};
    tbl.push_back(rw);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [6:0] e_inta_b;
    logic [6:0] e_lock_b;
    logic [6:0] e_valid_b;

    rst_n = 1'b0;
    intr = 1'b0; if_en = 1'b0; instr_boundary = 1'b0; vec_ready = 1'b0; vec_in = 8'h00;
    intr_b = 1'b0; if_en_b = 1'b0; instr_boundary_b = 1'b0; vec_ready_b = 1'b0; vec_in_b = 8'h00;
    repeat (3) step();
    chk("reset_state", {19'd0, inta_n, lock_n, vec_valid, busy, spurious, vec},
        {19'd0, 13'b1_1_0_0_0_00000000});
    rst_n = 1'b1;
    step();

    // interrupts disabled, or no request: nothing starts
    add(1'b1, 1'b0, 1'b1, 1'b1, 8'h09, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    add(1'b1, 1'b0, 1'b1, 1'b1, 8'h09, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    add(1'b0, 1'b1, 1'b1, 1'b1, 8'h09, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    add(1'b1, 1'b1, 1'b0, 1'b1, 8'h09, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    // normal acknowledge, vector 09, ready held high throughout
    add(1'b1, 1'b1, 1'b1, 1'b1, 8'h09, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    add(1'b1, 1'b1, 1'b0, 1'b1, 8'h09, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    add(1'b1, 1'b1, 1'b0, 1'b1, 8'h09, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    add(1'b1, 1'b1, 1'b0, 1'b1, 8'h09, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    add(1'b1, 1'b1, 1'b0, 1'b1, 8'h09, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    add(1'b1, 1'b1, 1'b0, 1'b1, 8'h09, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    add(1'b1, 1'b1, 1'b0, 1'b1, 8'h09, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h09);
    add(1'b1, 1'b1, 1'b0, 1'b1, 8'h09, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h09);
    add(1'b1, 1'b1, 1'b0, 1'b1, 8'h09, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h09);
    // spurious vector 00 is replaced by 0F
    add(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h09);
    add(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h09);
    add(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h09);
    add(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h09);
    add(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h09);
    add(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h09);
    add(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h0F);
    add(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h0F);

    for (int i = 0; i < tbl.size(); i++) begin
      intr = tbl[i].intr; if_en = tbl[i].if_en; instr_boundary = tbl[i].bnd;
      vec_ready = tbl[i].rdy; vec_in = tbl[i].vin;
      step();
      chk($sformatf("tbl[%0d]", i), {19'd0, inta_n, lock_n, vec_valid, busy, spurious, vec},
          {19'd0, tbl[i].exp});
    end

    // ready stall with request withdrawn during GAP
    intr = 1'b1; if_en = 1'b1; instr_boundary = 1'b1; vec_ready = 1'b0; vec_in = 8'h0A;
    step();
    instr_boundary = 1'b0;
    chk("stall_busy_c1", {31'd0, busy}, 32'd1);
    step(); step();
    intr = 1'b0; if_en = 1'b0;
    chk("stall_gap_inta", {30'd0, inta_n, lock_n}, {30'd0, 2'b10});
    repeat (4) step();
    chk("stall_c7_strobes", {29'd0, inta_n, lock_n, spurious}, {29'd0, 3'b110});
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall_hold[%0d]", k), {23'd0, vec_valid, vec}, {23'd0, 1'b1, 8'h0A});
      if (k == 4) vec_ready = 1'b1;
      step();
    end
    vec_ready = 1'b0;
    chk("stall_release", {22'd0, vec_valid, busy, vec}, {22'd0, 2'b00, 8'h0A});

    // asynchronous reset in the middle of ACK2
    intr = 1'b1; if_en = 1'b1; instr_boundary = 1'b1; vec_ready = 1'b1; vec_in = 8'h09;
    step();
    instr_boundary = 1'b0;
    repeat (4) step();
    chk("rst_pre_ack2_inta", {31'd0, inta_n}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", {19'd0, inta_n, lock_n, vec_valid, busy, spurious, vec},
        {19'd0, 13'b1_1_0_0_0_00000000});
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("rst_quiet[%0d]", k), {29'd0, inta_n, lock_n, busy}, {29'd0, 3'b110});
    end
    intr = 1'b0; if_en = 1'b0;

    // PULSE_LEN=1, GAP_LEN=3 instance; bit c-1 holds the cycle-c expectation
    e_inta_b  = 7'b1101110;
    e_lock_b  = 7'b1100000;
    e_valid_b = 7'b0100000;
    intr_b = 1'b1; if_en_b = 1'b1; instr_boundary_b = 1'b1; vec_ready_b = 1'b1; vec_in_b = 8'h0B;
    for (int c = 1; c <= 7; c++) begin
      step();
      instr_boundary_b = 1'b0;
      chk($sformatf("sweep_c%0d", c), {29'd0, inta_n_b, lock_n_b, vec_valid_b},
          {29'd0, e_inta_b[c-1], e_lock_b[c-1], e_valid_b[c-1]});
      if (c == 6) chk("sweep_vec", {23'd0, spurious_b, vec_b}, {23'd0, 1'b0, 8'h0B});
    end
    intr_b = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
